// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: stall requests, redirect and stall/discard/perf outputs of the hazard controller
interface pipe_hazard_ctrl_if #(parameter int PERF_W = 32);
  logic              if_stall_req;
  logic              id_stall_req;
  logic              ex_stall_req;
  logic              mem_stall_req;
  logic              ex_jump;
  logic [5:0]        stall;
  logic              discard_if_id;
  logic              discard_id_ex;
  logic              flush_pending;
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_count;
  modport master (
    output if_stall_req, id_stall_req, ex_stall_req, mem_stall_req, ex_jump,
    input  stall, discard_if_id, discard_id_ex, flush_pending, stall_cycles, flush_count
  );
  modport slave (
    input  if_stall_req, id_stall_req, ex_stall_req, mem_stall_req, ex_jump,
    output stall, discard_if_id, discard_id_ex, flush_pending, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush controller with pending-flush state; PIPE_HAZARD_PERF_EN adds perf counters
module pipe_hazard_ctrl #(
  parameter int PERF_W = 32
) (
  input logic              clock,
  input logic              reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] PEND = 1'b1;
  logic [0:0] state, state_nx;
  logic [5:0] stall_v;
  logic       jump_taken;
  // highest requester wins; everything is forced quiet while reset is held
  always_comb begin
    stall_v = bus.mem_stall_req ? 6'b011111 :
              bus.ex_stall_req  ? 6'b001111 :
              bus.id_stall_req  ? 6'b000111 :
              bus.if_stall_req  ? 6'b000011 : 6'b000000;
    jump_taken = reset & bus.ex_jump & ~stall_v[3];
    bus.stall = reset ? stall_v : 6'b000000;
    bus.discard_id_ex = jump_taken;
    bus.discard_if_id = reset & ((state == PEND) ? ~stall_v[1] : (jump_taken & ~bus.if_stall_req));
    bus.flush_pending = reset & (state == PEND);
    state_nx = (state == PEND) ? (stall_v[1] ? PEND : RUN) : ((jump_taken & bus.if_stall_req) ? PEND : RUN);
  end
  // pending-flush state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= RUN;
    else state <= state_nx;
`ifdef PIPE_HAZARD_PERF_EN
  logic [PERF_W-1:0] sc, fc;
  // free-running wrap-around counters of stalled cycles and accepted redirects
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      sc <= '0;
      fc <= '0;
    end else begin
      sc <= sc + PERF_W'(stall_v[0]);
      fc <= fc + PERF_W'(jump_taken);
    end
  assign bus.stall_cycles = sc;
  assign bus.flush_count = fc;
`else
  assign bus.stall_cycles = {PERF_W{1'b0}};
  assign bus.flush_count = {PERF_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of stall vector, discards, pending flush and perf counters
module tb_pipe_hazard_ctrl;
`ifdef PIPE_HAZARD_PERF_EN
  localparam int PW = 4;
`else
  localparam int PW = 32;
`endif
  logic clock, reset;
  int total = 0, bad = 0;
  pipe_hazard_ctrl_if #(.PERF_W(PW)) bus ();
  pipe_hazard_ctrl #(.PERF_W(PW)) dut (.clock(clock), .reset(reset), .bus(bus));
  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clock);
    @(negedge clock);
  endtask
  task automatic drive(input logic i, input logic d, input logic e, input logic m, input logic j);
    bus.if_stall_req = i;
    bus.id_stall_req = d;
    bus.ex_stall_req = e;
    bus.mem_stall_req = m;
    bus.ex_jump = j;
    #1;
  endtask
  task automatic outs(input string tag, input logic [5:0] s, input logic dif, input logic dix, input logic fp);
    chk({tag, ".stall"}, 32'(bus.stall), 32'(s));
    chk({tag, ".dif"}, 32'(bus.discard_if_id), 32'(dif));
    chk({tag, ".dix"}, 32'(bus.discard_id_ex), 32'(dix));
    chk({tag, ".fp"}, 32'(bus.flush_pending), 32'(fp));
  endtask
  initial begin
    reset = 0;
    drive(0, 0, 0, 1, 1);
    outs("rst_hold", 6'b000000, 0, 0, 0);
    step;
    outs("rst_hold2", 6'b000000, 0, 0, 0);
    chk("rst_sc", 32'(bus.stall_cycles), 0);
    chk("rst_fc", 32'(bus.flush_count), 0);
    reset = 1;
    #1;
    outs("rst_rel", 6'b011111, 0, 0, 0);
    step;
    drive(0, 1, 0, 0, 0);
    outs("id", 6'b000111, 0, 0, 0);
    step;
    drive(0, 0, 0, 0, 0);
    outs("idle", 6'b000000, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    outs("ex", 6'b001111, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    outs("if", 6'b000011, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    outs("jmp", 6'b000000, 1, 1, 0);
    step;
    drive(0, 0, 0, 0, 0);
    outs("jmp_after", 6'b000000, 0, 0, 0);
    drive(1, 0, 0, 0, 1);
    outs("pend_c0", 6'b000011, 0, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      step;
      drive(1, 0, 0, 0, 0);
      outs($sformatf("pend_c%0d", k), 6'b000011, 0, 0, 1);
    end
    step;
    drive(0, 0, 0, 0, 0);
    outs("pend_c4", 6'b000000, 1, 0, 1);
    step;
    outs("pend_c5", 6'b000000, 0, 0, 0);
    drive(1, 0, 0, 0, 1);
    outs("pj_c0", 6'b000011, 0, 1, 0);
    step;
    drive(1, 0, 0, 0, 1);
    outs("pj_c1", 6'b000011, 0, 1, 1);
    step;
    drive(0, 0, 0, 0, 1);
    outs("pj_c2", 6'b000000, 1, 1, 1);
    step;
    drive(0, 0, 0, 0, 0);
    outs("pj_c3", 6'b000000, 0, 0, 0);
    drive(0, 0, 0, 1, 1);
    outs("mj_c0", 6'b011111, 0, 0, 0);
    step;
    drive(0, 0, 0, 1, 1);
    outs("mj_c1", 6'b011111, 0, 0, 0);
    step;
    drive(0, 0, 0, 0, 1);
    outs("mj_c2", 6'b000000, 1, 1, 0);
    step;
    drive(1, 0, 0, 0, 1);
    step;
    drive(1, 0, 0, 0, 0);
    chk("arst_pre_fp", 32'(bus.flush_pending), 1);
    reset = 0;
    #1;
    outs("arst", 6'b000000, 0, 0, 0);
    chk("arst_sc", 32'(bus.stall_cycles), 0);
    chk("arst_fc", 32'(bus.flush_count), 0);
    reset = 1;
    drive(1, 0, 0, 0, 0);
    for (int k = 0; k < 17; k++) step;
    drive(0, 0, 0, 0, 0);
`ifdef PIPE_HAZARD_PERF_EN
    chk("sc_wrap", 32'(bus.stall_cycles), 1);
`else
    chk("sc_off", 32'(bus.stall_cycles), 0);
`endif
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 1);
      step;
      drive(0, 0, 0, 0, 0);
      step;
    end
`ifdef PIPE_HAZARD_PERF_EN
    chk("fc", 32'(bus.flush_count), 2);
    chk("sc_hold", 32'(bus.stall_cycles), 1);
`else
    chk("fc_off", 32'(bus.flush_count), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RISC-V pipeline (PC, IF, ID, EX, MEM, WB).
- Collects per-stage stall requests and the EX branch/jump redirect.
- Drives the shared stall vector consumed by every pipe_* register, plus the per-register discard strobes.
- Holds a pending-flush state so that a redirect taken while an instruction fetch is still in flight kills the stale instruction when that fetch returns.

Parameters:
- PERF_W, 32, width of the optional performance counters.

Ports:
- clock  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- if_stall_req  in  1  IF memory fetch not complete.
- id_stall_req  in  1  ID load-use hazard.
- ex_stall_req  in  1  EX multi-cycle operation busy.
- mem_stall_req  in  1  MEM data access not complete.
- ex_jump  in  1  EX resolves a taken branch or jump (redirect).
- stall  out  6  stall[i]=1 holds stage i (0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB).
- discard_if_id  out  1  zero the IF/ID register this edge.
- discard_id_ex  out  1  zero the ID/EX register this edge.
- flush_pending  out  1  high while in state PEND.
- stall_cycles  out  PERF_W  cycles with stall[0]=1 (PIPE_HAZARD_PERF_EN only).
- flush_count  out  PERF_W  accepted redirects (PIPE_HAZARD_PERF_EN only).

Behaviour:
- Reset (reset=0, asynchronous): state=RUN; all outputs 0; counters 0. While reset is held, outputs stay 0 regardless of inputs.
- Stall vector is combinational from the requests, highest requester wins:
  - mem_stall_req -> stall=6'b011111.
  - else ex_stall_req -> 6'b001111.
  - else id_stall_req -> 6'b000111.
  - else if_stall_req -> 6'b000011.
  - else 6'b000000.
  - stall[5] is always 0.
- Consumer rule (fixed): a register between stage i and i+1 inserts a bubble when stall[i]=1 and stall[i+1]=0, and holds when both are 1.
- jump_taken = ex_jump & ~stall[3]. A jump raised while EX is held is ignored until EX advances; EX keeps ex_jump asserted during that time.
- discard_id_ex = jump_taken (combinational).
- State RUN:
  - jump_taken & ~if_stall_req -> discard_if_id=1 this cycle; stay RUN.
  - jump_taken & if_stall_req -> discard_if_id=0; next state PEND.
- State PEND (the in-flight fetch is wrong-path):
  - discard_if_id = ~stall[1]. Asserted in the first cycle IF is not held, i.e. the stale instruction's capture edge; next state RUN.
  - While stall[1]=1, remain in PEND and keep discard_if_id=0.
  - jump_taken in PEND: discard_id_ex=1; state unchanged (a single pending kill covers it).
  - jump_taken in the same cycle as exit (stall[1]=0): discard_if_id=1; next state RUN.
- flush_pending = (state==PEND).
- State and counters update on posedge clock only. All other outputs are combinational from the current state and inputs, with zero latency.
- Simultaneous mem_stall_req and ex_jump: jump is ignored (stall[3]=1); no discards.

Optional Feature:
- Macro PIPE_HAZARD_PERF_EN.
- Defined: stall_cycles increments each cycle with stall[0]=1; flush_count increments on each jump_taken. Both wrap modulo 2^PERF_W and clear on reset.
- Undefined: counter logic is absent and both outputs are tied to 0.

Test Plan:
- Reset low with mem_stall_req=1, ex_jump=1 -> stall=0, discards=0, flush_pending=0. Release reset -> stall=6'b011111.
- id_stall_req=1 only for 1 cycle -> stall=6'b000111 that cycle, then 0; discard_* remain 0.
- ex_jump=1, all requests 0 -> discard_if_id=1 and discard_id_ex=1 for 1 cycle; state stays RUN.
- ex_jump=1 with if_stall_req=1, then if_stall_req held 3 more cycles -> discard_id_ex=1 in cycle 0 only; flush_pending=1 for cycles 1-3; discard_if_id=1 exactly in cycle 4 (if_stall_req=0); flush_pending=0 in cycle 5.
- ex_jump=1 with mem_stall_req=1 for 2 cycles, then mem_stall_req=0 -> no discards during cycles 0-1; both discards=1 in cycle 2.
- PIPE_HAZARD_PERF_EN, PERF_W=4: 17 cycles with if_stall_req=1 -> stall_cycles=1 (wrap). 2 isolated jumps -> flush_count=2.
